// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM input-capture receiver.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} cap_state_t;

  // Largest count a bits-wide counter can hold before it would wrap.
  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioner: 2-flop synchroniser, optional glitch filter (PWM_GLITCH_FILTER_EN), edge detect.
// Edge latency from pwm_in is identical for rising and falling edges.
module pwm_in_cond
  import pwm_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic pwm_s;
  logic pwm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [CW-1:0] filt_cnt;

  // Output follows the synchronised input only once it has disagreed for FILT_LEN samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_s    <= 1'b0;
      filt_cnt <= '0;
    end else if (sync2 == pwm_s) begin
      filt_cnt <= '0;
    end else if (filt_cnt == CW'(FILT_LEN - 1)) begin
      pwm_s    <= sync2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
`else
  assign pwm_s = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_d <= 1'b0;
    end else begin
      pwm_d <= pwm_s;
    end
  end

  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;
  assign level = pwm_s;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("pwm_in_cond: FILT_LEN must be at least 1");
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period (rise-to-rise) and high time of pwm_in in clk cycles.
// Optional input glitch filter enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int BITS     = 15,
  parameter int FILT_LEN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            pwm_in,
  output logic [BITS-1:0] period,
  output logic [BITS-1:0] high_time,
  output logic            valid,
  output logic            timeout,
  output logic            level
);

  localparam logic [BITS-1:0] CNT_MAX = BITS'(cnt_max(BITS));
  localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

  cap_state_t      state;
  logic [BITS-1:0] per_cnt;
  logic [BITS-1:0] hi_cnt;
  logic [BITS-1:0] hi_lat;
  logic            rise;
  logic            fall;
  logic            at_max;

  pwm_in_cond #(
    .FILT_LEN (FILT_LEN)
  ) u_cond (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign at_max = (per_cnt == CNT_MAX);

  // A rise always wins over saturation, so a maximal-length period is still reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            state   <= ARM;
          end
          ARM: begin
            if (rise) begin
              per_cnt <= CNT_ONE;
              hi_cnt  <= CNT_ONE;
              state   <= HIGH;
            end else if (at_max) begin
              timeout <= 1'b1;
              per_cnt <= '0;
              hi_cnt  <= '0;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          HIGH: begin
            if (at_max) begin
              timeout <= 1'b1;
              per_cnt <= '0;
              hi_cnt  <= '0;
              state   <= ARM;
            end else if (fall) begin
              hi_lat  <= hi_cnt;
              per_cnt <= per_cnt + 1'b1;
              state   <= LOW;
            end else begin
              per_cnt <= per_cnt + 1'b1;
              hi_cnt  <= hi_cnt + 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              period    <= per_cnt;
              high_time <= hi_lat;
              valid     <= 1'b1;
              per_cnt   <= CNT_ONE;
              hi_cnt    <= CNT_ONE;
              state     <= HIGH;
            end else if (at_max) begin
              timeout <= 1'b1;
              per_cnt <= '0;
              hi_cnt  <= '0;
              state   <= ARM;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: each driven rise queues the measurement of the pulse it completes;
// reports are popped and compared as valid fires, plus reset, enable, rst and timeout cases.
module tb_pwm_capture;

  localparam int BITS = 15;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  // enable sampled on the first edge, then 32767 counts, then the pulse registers
  localparam int TO_LAT   = 32769;
  localparam int TO_BOUND = 33000;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            pwm_in;
  logic [BITS-1:0] period;
  logic [BITS-1:0] high_time;
  logic            valid;
  logic            timeout;
  logic            level;

  typedef struct {
    int p;
    int h;
    int c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  bit   have_prev;
  int   prev_p;
  int   prev_h;
  bit   allow_to;

  pwm_capture #(
    .BITS     (BITS),
    .FILT_LEN (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // A rise completes the previously driven pulse, if capture was already running.
  task automatic start_rise(input int p, input int h);
    if (have_prev) sb.push_back('{prev_p, prev_h, cyc});
    have_prev = 1'b1;
    prev_p    = p;
    prev_h    = h;
  endtask

  task automatic pulse(input int p, input int h);
    start_rise(p, h);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic drain(input string tag);
    repeat (8) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_timeout(input string tag, input logic lvl);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < TO_BOUND && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (timeout) got = 1'b1;
    end
    chk({tag, "_lat"}, n, TO_LAT);
    chk({tag, "_lvl"}, level, lvl);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, timeout, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        chk("valid_unexp", valid, 0);
      end else begin
        e = sb.pop_front();
        chk("period", period, e.p);
        chk("high_time", high_time, e.h);
        chk("valid_lat", cyc - e.c, LAT);
      end
    end
    if (!rst && timeout && !allow_to) chk("timeout_unexp", timeout, 0);
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    pwm_in    = 1'b0;
    have_prev = 1'b0;
    allow_to  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;
    @(negedge clk);

    // steady 256/64, then duty change at a period boundary
    enable = 1'b1;
    repeat (4) pulse(256, 64);
    repeat (2) pulse(256, 200);
`ifndef PWM_GLITCH_FILTER_EN
    repeat (4) pulse(2, 1);
`endif

    // enable dropped mid-HIGH, re-raised 100 cycles later
    start_rise(256, 64);
    hold(1'b1, 30);
    enable    = 1'b0;
    have_prev = 1'b0;
    hold(1'b1, 34);
`ifndef PWM_GLITCH_FILTER_EN
    chk("held_period", period, 2);
    chk("held_high", high_time, 1);
`else
    chk("held_period", period, 256);
    chk("held_high", high_time, 200);
`endif
    hold(1'b0, 66);
    enable = 1'b1;
    hold(1'b0, 126);
    pulse(256, 64);
    pulse(256, 64);

    // rst pulsed mid-LOW
    start_rise(256, 64);
    hold(1'b1, 64);
    hold(1'b0, 50);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_period", period, 0);
    chk("arst_high", high_time, 0);
    chk("arst_valid", valid, 0);
    chk("arst_level", level, 0);
    @(negedge clk);
    rst       = 1'b0;
    have_prev = 1'b0;
    hold(1'b0, 141);
    pulse(256, 64);
    pulse(256, 64);

`ifdef PWM_GLITCH_FILTER_EN
    // 2-cycle glitch in LOW is swallowed; a 3-cycle pulse survives
    start_rise(256, 64);
    hold(1'b1, 64);
    hold(1'b0, 100);
    hold(1'b1, 2);
    hold(1'b0, 90);
    pulse(256, 3);
`endif

    start_rise(256, 64);
    hold(1'b1, 64);
    enable = 1'b0;
    hold(1'b0, 20);
    drain("sb_drain");

    // no edges at all: 0% then 100% duty
    allow_to = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_timeout("to0", 1'b0);
    @(negedge clk);
    enable = 1'b0;
    pwm_in = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    wait_timeout("to1", 1'b1);
    @(negedge clk);
    enable = 1'b0;
    chk("to_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
